uart_cfg: RTL

//  Next-generation UART for the SoC peripheral bus: independent TX and RX engines, each with its own sync FIFO.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_sync_fifo.sv | 48 ++++
 rtl/uart_cfg.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared encodings, FSM state types and helpers for the uart_cfg peripheral.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;
    localparam int MIN_DIV  = 4;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Parity bit that makes XOR(data, bit) equal 0 (even) or 1 (odd).
    function automatic logic parity_bit(input int par, input logic data_xor);
        return (par == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry an extra wrap bit for full/empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_rd_ok;
    logic             w_wr_ok;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so push+pop on a full FIFO both succeed.
    assign w_rd_ok = i_rd && !o_empty;
    assign w_wr_ok = i_wr && (!o_full || w_rd_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_cfg.sv
// uart_cfg: UART with independent TX/RX engines and FIFOs, compile-time frame format.
// Defining UART_LOOPBACK_EN adds a loopback port routing TX back into RX.
module uart_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    input  logic                 tx_push,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic                 rx_valid,
    input  logic                 rx_pop,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_overrun,
    input  logic                 rx_ovr_clr
);

    localparam logic       HAS_PAR   = (PARITY != PAR_NONE);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
    endfunction

    // ---------------- TX engine ----------------
    tx_state_t            r_tx_state;
    tx_state_t            w_tx_nxt;
    logic [DIV_W-1:0]     r_tx_div;
    logic [DIV_W-1:0]     r_tx_cnt;
    logic [3:0]           r_tx_idx;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx_line;
    logic                 w_tx_tick;
    logic                 w_tx_pop;
    logic                 w_tx_ser;
    logic [DATA_BITS-1:0] w_txf_rdata;
    logic                 w_txf_full;
    logic                 w_txf_empty;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (tx_push),
        .i_wdata (tx_data),
        .i_rd    (w_tx_pop),
        .o_rdata (w_txf_rdata),
        .o_full  (w_txf_full),
        .o_empty (w_txf_empty)
    );

    assign w_tx_tick = (r_tx_cnt == r_tx_div - DIV_W'(1));

    always_comb begin
        w_tx_nxt = r_tx_state;
        w_tx_pop = 1'b0;
        w_tx_ser = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                if (!w_txf_empty) begin
                    w_tx_pop = 1'b1;
                    w_tx_nxt = TX_START;
                end
            end
            TX_START: begin
                w_tx_ser = 1'b0;
                if (w_tx_tick) w_tx_nxt = TX_DATA;
            end
            TX_DATA: begin
                w_tx_ser = r_tx_shift[0];
                if (w_tx_tick && r_tx_idx == LAST_DATA)
                    w_tx_nxt = HAS_PAR ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                w_tx_ser = r_tx_par;
                if (w_tx_tick) w_tx_nxt = TX_STOP;
            end
            TX_STOP: begin
                // Chain straight into the next START so queued frames leave no idle gap.
                if (w_tx_tick && r_tx_idx == LAST_STOP) begin
                    if (!w_txf_empty) begin
                        w_tx_pop = 1'b1;
                        w_tx_nxt = TX_START;
                    end else begin
                        w_tx_nxt = TX_IDLE;
                    end
                end
            end
            default: w_tx_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_tx_state <= TX_IDLE;
        else     r_tx_state <= w_tx_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_cnt  <= '0;
            r_tx_idx  <= '0;
            r_tx_line <= 1'b1;
        end else begin
            r_tx_line <= w_tx_ser;
            if (r_tx_state == TX_IDLE || w_tx_pop || w_tx_nxt != r_tx_state) begin
                r_tx_cnt <= '0;
                r_tx_idx <= '0;
            end else if (w_tx_tick) begin
                r_tx_cnt <= '0;
                r_tx_idx <= r_tx_idx + 4'd1;
            end else begin
                r_tx_cnt <= r_tx_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_pop) begin
            r_tx_shift <= w_txf_rdata;
            r_tx_par   <= parity_bit(PARITY, ^w_txf_rdata);
            r_tx_div   <= clamp_div(baud_div);
        end else if (r_tx_state == TX_DATA && w_tx_tick) begin
            r_tx_shift <= r_tx_shift >> 1;
        end
    end

    assign tx_full = w_txf_full;
    assign tx_busy = !w_txf_empty || (r_tx_state != TX_IDLE);

    // ---------------- RX engine ----------------
    logic                   w_rx_in;
    logic                   r_rx_s1;
    logic                   r_rx_s2;
    logic                   r_rx_prev;
    rx_state_t              r_rx_state;
    rx_state_t              w_rx_nxt;
    logic [DIV_W-1:0]       r_rx_div;
    logic [DIV_W-1:0]       r_rx_cnt;
    logic [3:0]             r_rx_idx;
    logic [DATA_BITS-1:0]   r_rx_shift;
    logic                   r_rx_pbit;
    logic                   r_rx_ovr;
    logic                   w_rx_tick;
    logic                   w_rx_half;
    logic                   w_rx_push;
    logic                   w_rx_perr;
    logic                   w_rx_drop;
    logic [DATA_BITS+1:0]   w_rx_wdata;
    logic [DATA_BITS+1:0]   w_rxf_rdata;
    logic                   w_rxf_full;
    logic                   w_rxf_empty;

`ifdef UART_LOOPBACK_EN
    assign w_rx_in = loopback ? r_tx_line : uart_rx;
    assign uart_tx = loopback ? 1'b1 : r_tx_line;
`else
    assign w_rx_in = uart_rx;
    assign uart_tx = r_tx_line;
`endif

    assign w_rx_tick = (r_rx_cnt == r_rx_div - DIV_W'(1));
    assign w_rx_half = (r_rx_cnt == (r_rx_div >> 1) - DIV_W'(1));

    always_comb begin
        w_rx_nxt  = r_rx_state;
        w_rx_push = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                // Requires a seen-high line, so a low stop bit cannot retrigger.
                if (r_rx_prev && !r_rx_s2) w_rx_nxt = RX_START;
            end
            RX_START: begin
                if (w_rx_half) w_rx_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (w_rx_tick && r_rx_idx == LAST_DATA)
                    w_rx_nxt = HAS_PAR ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (w_rx_tick) w_rx_nxt = RX_STOP;
            end
            RX_STOP: begin
                if (w_rx_tick) begin
                    w_rx_push = 1'b1;
                    w_rx_nxt  = RX_IDLE;
                end
            end
            default: w_rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_rx_state <= RX_IDLE;
        else     r_rx_state <= w_rx_nxt;
    end

    assign w_rx_perr  = HAS_PAR && (r_rx_pbit != parity_bit(PARITY, ^r_rx_shift));
    assign w_rx_wdata = {~r_rx_s2, w_rx_perr, r_rx_shift};
    assign w_rx_drop  = w_rx_push && w_rxf_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_rx_cnt  <= '0;
            r_rx_idx  <= '0;
            r_rx_ovr  <= 1'b0;
        end else begin
            r_rx_s1   <= w_rx_in;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            if (r_rx_state == RX_IDLE || w_rx_nxt != r_rx_state) begin
                r_rx_cnt <= '0;
                r_rx_idx <= '0;
            end else if (w_rx_tick) begin
                r_rx_cnt <= '0;
                r_rx_idx <= r_rx_idx + 4'd1;
            end else begin
                r_rx_cnt <= r_rx_cnt + DIV_W'(1);
            end
            if (w_rx_drop)       r_rx_ovr <= 1'b1;
            else if (rx_ovr_clr) r_rx_ovr <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (r_rx_state == RX_IDLE && w_rx_nxt == RX_START)
            r_rx_div <= clamp_div(baud_div);
        if (r_rx_state == RX_DATA && w_rx_tick)
            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
        if (r_rx_state == RX_PARITY && w_rx_tick)
            r_rx_pbit <= r_rx_s2;
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_rx_push),
        .i_wdata (w_rx_wdata),
        .i_rd    (rx_pop),
        .o_rdata (w_rxf_rdata),
        .o_full  (w_rxf_full),
        .o_empty (w_rxf_empty)
    );

    // Head fields read as zero while empty so outputs are defined from reset.
    assign rx_valid   = !w_rxf_empty;
    assign rx_data    = rx_valid ? w_rxf_rdata[DATA_BITS-1:0] : '0;
    assign rx_perr    = rx_valid & w_rxf_rdata[DATA_BITS];
    assign rx_ferr    = rx_valid & w_rxf_rdata[DATA_BITS+1];
    assign rx_overrun = r_rx_ovr;

endmodule
